// File: rtl/operate_pkg.sv
// Shared definitions for the operate engine: opcodes, FSM states, fault codes.
package operate_pkg;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_RSH  = 8'h02;
    localparam logic [7:0] OP_LSH  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_INV  = 8'h07;
    localparam logic [7:0] OP_JMP  = 8'h08;
    localparam logic [7:0] OP_JEQ0 = 8'h09;
    localparam logic [7:0] OP_JGT0 = 8'h0A;
    localparam logic [7:0] OP_JLT0 = 8'h0B;
    localparam logic [7:0] OP_LDC  = 8'h0C;
    localparam logic [7:0] OP_COPY = 8'h0D;
    localparam logic [7:0] OP_CALL = 8'h0E;
    localparam logic [7:0] OP_HALT = 8'h0F;
    localparam logic [7:0] OP_RET  = 8'h10;
    localparam logic [7:0] OP_JC   = 8'h11;
    localparam logic [7:0] OP_MAX  = OP_JC;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_RD_A, S_RD_B, S_EXEC, S_WR, S_DONE, S_FAULT
    } state_t;

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_ILLEGAL   = 2'd1;
    localparam logic [1:0] FC_OVERFLOW  = 2'd2;
    localparam logic [1:0] FC_UNDERFLOW = 2'd3;

    // ALU ops that read both opA (a2) and opB (a3)
    function automatic logic is_two_operand(input logic [7:0] op);
        return op <= OP_XOR;
    endfunction

    // ops that read only opA (a2)
    function automatic logic is_one_operand(input logic [7:0] op);
        return op inside {OP_INV, OP_JEQ0, OP_JGT0, OP_JLT0, OP_COPY};
    endfunction

endpackage

// File: rtl/operate_core_if.sv
// Data memory req/ready bus between the engine (master) and memory (slave).
interface operate_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/operate_call_stack.sv
// Bounded LIFO of return addresses; push/pop are ignored when full/empty.
module operate_call_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] FULL_SP = SPW'(DEPTH);

    logic [SPW-1:0] sp;
    logic [W-1:0]   ent [DEPTH];

    assign full  = (sp == FULL_SP);
    assign empty = (sp == '0);
    assign top   = empty ? '0 : ent[IW'(sp - SPW'(1))];

    // stack pointer: cleared by reset or at program start
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                sp <= '0;
        else if (clear)           sp <= '0;
        else if (push && !full)   sp <= sp + SPW'(1);
        else if (pop && !empty)   sp <= sp - SPW'(1);
    end

    // entry storage needs no reset; sp defines which entries are live
    always_ff @(posedge clk) begin
        if (push && !full && !clear) ent[IW'(sp)] <= din;
    end
endmodule

// File: rtl/operate_core.sv
// Multi-cycle operate engine: fetch from ROM, operands/results via req/ready memory.
module operate_core
    import operate_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int INSTR_W     = 8 + 3*ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ack,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    operate_core_if.master     mem,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic               carry
);
    localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

    state_t               state, nxt;
    logic [INSTR_W-1:0]   ir;
    logic [DATA_W-1:0]    opa, opb, alu_res;
    logic                 alu_c;
    logic [DATA_W:0]      sum, diff;
    logic [DATA_W+ADDR_W-1:0] ldc_ext;
    logic [ADDR_W-1:0]    pc_inc, flow_pc, stk_top;
    logic                 stk_push, stk_pop, stk_full, stk_empty;
    logic [1:0]           fc_nxt;
    logic [7:0]           f_op, i_op;
    logic [ADDR_W-1:0]    f_a2, i_a1, i_a2, i_a3;
    logic                 ready;

    assign f_op  = instr[INSTR_W-1 -: 8];
    assign f_a2  = instr[2*ADDR_W-1 -: ADDR_W];
    assign i_op  = ir[INSTR_W-1 -: 8];
    assign i_a1  = ir[3*ADDR_W-1 -: ADDR_W];
    assign i_a2  = ir[2*ADDR_W-1 -: ADDR_W];
    assign i_a3  = ir[ADDR_W-1:0];
    assign ready = mem.mem_ready;
    assign pc_inc = pc + ADDR_W'(1);

    // request lines decode straight from state so reset drops them at once
    assign mem.mem_req = (state == S_RD_A) || (state == S_RD_B) || (state == S_WR);
    assign mem.mem_we  = (state == S_WR);
    assign busy  = !(state inside {S_IDLE, S_DONE, S_FAULT});
    assign done  = (state == S_DONE);
    assign fault = (state == S_FAULT);

    operate_call_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
        .clk   (clk),
        .reset (reset),
        .clear (state == S_IDLE && start),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .full  (stk_full),
        .empty (stk_empty),
        .top   (stk_top)
    );

    // ALU result/carry and next pc for flow-control ops
    always_comb begin
        sum     = {1'b0, opa} + {1'b0, opb};
        diff    = {1'b0, opa} - {1'b0, opb};
        ldc_ext = {{DATA_W{1'b0}}, i_a2};
        alu_res = opa;
        alu_c   = carry;
        case (i_op)
            OP_ADD:  begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
            OP_SUB:  begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
            OP_RSH:  alu_res = (opb >= SH_LIM) ? '0 : (opa >> opb);
            OP_LSH:  alu_res = (opb >= SH_LIM) ? '0 : (opa << opb);
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_INV:  alu_res = ~opa;
            OP_LDC:  alu_res = ldc_ext[DATA_W-1:0];
            default: alu_res = opa;
        endcase
        flow_pc = pc_inc;
        case (i_op)
            OP_JMP:  flow_pc = i_a1;
            OP_JEQ0: if (opa == '0) flow_pc = i_a1;
            OP_JGT0: if (!opa[DATA_W-1] && opa != '0) flow_pc = i_a1;
            OP_JLT0: if (opa[DATA_W-1]) flow_pc = i_a1;
            OP_CALL: flow_pc = i_a1;
            OP_RET:  flow_pc = stk_top;
            OP_JC:   if (carry) flow_pc = i_a1;
            default: flow_pc = pc_inc;
        endcase
    end

    // next-state decode plus stack strobes and fault cause
    always_comb begin
        nxt      = state;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        fc_nxt   = FC_NONE;
        case (state)
            S_IDLE:  if (start) nxt = S_FETCH;
            S_FETCH: begin
                if (f_op > OP_MAX) begin
                    nxt    = S_FAULT;
                    fc_nxt = FC_ILLEGAL;
                end else if (is_two_operand(f_op) || is_one_operand(f_op)) begin
                    nxt = S_RD_A;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_RD_A:  if (ready) nxt = is_two_operand(i_op) ? S_RD_B : S_EXEC;
            S_RD_B:  if (ready) nxt = S_EXEC;
            S_EXEC: begin
                case (i_op)
                    OP_JMP, OP_JEQ0, OP_JGT0, OP_JLT0, OP_JC: nxt = S_FETCH;
                    OP_CALL: begin
                        if (stk_full) begin
                            nxt    = S_FAULT;
                            fc_nxt = FC_OVERFLOW;
                        end else begin
                            stk_push = 1'b1;
                            nxt      = S_FETCH;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            nxt    = S_FAULT;
                            fc_nxt = FC_UNDERFLOW;
                        end else begin
                            stk_pop = 1'b1;
                            nxt     = S_FETCH;
                        end
                    end
                    OP_HALT: nxt = S_DONE;
                    default: nxt = S_WR;
                endcase
            end
            S_WR:    if (ready) nxt = S_FETCH;
            S_DONE,
            S_FAULT: if (ack) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    // datapath: pc, instruction, operands, flags and held bus address/data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= '0;
            carry         <= 1'b0;
            fault_code    <= FC_NONE;
            ir            <= '0;
            opa           <= '0;
            opb           <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            if (nxt == S_FAULT && state != S_FAULT) fault_code <= fc_nxt;
            case (state)
                S_IDLE: if (start) begin
                    pc         <= '0;
                    carry      <= 1'b0;
                    fault_code <= FC_NONE;
                end
                S_FETCH: begin
                    ir           <= instr;
                    mem.mem_addr <= f_a2;
                end
                S_RD_A: if (ready) begin
                    opa          <= mem.mem_rdata;
                    mem.mem_addr <= i_a3;
                end
                S_RD_B: if (ready) opb <= mem.mem_rdata;
                S_EXEC: begin
                    if (nxt == S_WR) begin
                        mem.mem_addr  <= i_a1;
                        mem.mem_wdata <= alu_res;
                        carry         <= alu_c;
                    end else if (nxt == S_FETCH) begin
                        pc <= flow_pc;
                    end
                end
                S_WR: if (ready) pc <= pc_inc;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_operate_core.sv
// Directed bench: two engines (8/8 default, 16/10 with depth-2 stack) on model memories.
module tb_operate_core;
    import operate_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start_a, ack_a, start_b, ack_b;
    logic [31:0] instr_a;
    logic [37:0] instr_b;
    logic [7:0]  pc_a;
    logic [9:0]  pc_b;
    logic busy_a, done_a, fault_a, carry_a, busy_b, done_b, fault_b, carry_b;
    logic [1:0] fc_a, fc_b;

    logic [31:0] rom_a [256];
    logic [37:0] rom_b [1024];
    logic [7:0]  dm_a  [256];
    logic [15:0] dm_b  [1024];
    int waits_a, waits_b, wcnt_a, wcnt_b, xfer_a, xfer_b, viol_a;
    int total, bad, cyc, x0;
    logic       pend_a;
    logic [7:0] paddr_a, pwdata_a;

    operate_core_if #(.DATA_W(8),  .ADDR_W(8))  ifa ();
    operate_core_if #(.DATA_W(16), .ADDR_W(10)) ifb ();

    operate_core dut_a (
        .clk(clk), .reset(reset), .start(start_a), .ack(ack_a), .instr(instr_a),
        .pc(pc_a), .mem(ifa), .busy(busy_a), .done(done_a), .fault(fault_a),
        .fault_code(fc_a), .carry(carry_a));

    operate_core #(.DATA_W(16), .ADDR_W(10), .STACK_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .ack(ack_b), .instr(instr_b),
        .pc(pc_b), .mem(ifb), .busy(busy_b), .done(done_b), .fault(fault_b),
        .fault_code(fc_b), .carry(carry_b));

    initial forever #5 clk = ~clk;

    assign instr_a       = rom_a[pc_a];
    assign instr_b       = rom_b[pc_b];
    assign ifa.mem_ready = ifa.mem_req && (wcnt_a >= waits_a);
    assign ifb.mem_ready = ifb.mem_req && (wcnt_b >= waits_b);
    assign ifa.mem_rdata = dm_a[ifa.mem_addr];
    assign ifb.mem_rdata = dm_b[ifb.mem_addr];

    // memory model A: waits_a stall cycles before each transfer completes
    always @(posedge clk) begin
        if (ifa.mem_req) begin
            if (ifa.mem_ready) begin
                wcnt_a <= 0;
                xfer_a <= xfer_a + 1;
                if (ifa.mem_we) dm_a[ifa.mem_addr] <= ifa.mem_wdata;
            end else wcnt_a <= wcnt_a + 1;
        end else wcnt_a <= 0;
    end

    // memory model B
    always @(posedge clk) begin
        if (ifb.mem_req) begin
            if (ifb.mem_ready) begin
                wcnt_b <= 0;
                xfer_b <= xfer_b + 1;
                if (ifb.mem_we) dm_b[ifb.mem_addr] <= ifb.mem_wdata;
            end else wcnt_b <= wcnt_b + 1;
        end else wcnt_b <= 0;
    end

    // a pending request on A must stay asserted with unchanged address/data
    always @(negedge clk) begin
        if (reset) pend_a <= 1'b0;
        else begin
            if (pend_a && (!ifa.mem_req || ifa.mem_addr != paddr_a || ifa.mem_wdata != pwdata_a))
                viol_a <= viol_a + 1;
            pend_a   <= ifa.mem_req && !ifa.mem_ready;
            paddr_a  <= ifa.mem_addr;
            pwdata_a <= ifa.mem_wdata;
        end
    end

    function automatic logic [31:0] ia(input logic [7:0] op, input logic [7:0] a1, a2, a3);
        return {op, a1, a2, a3};
    endfunction

    function automatic logic [37:0] ib(input logic [7:0] op, input logic [9:0] a1, a2, a3);
        return {op, a1, a2, a3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom_a();
        for (int i = 0; i < 256; i++) rom_a[i] = ia(OP_HALT, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic clear_rom_b();
        for (int i = 0; i < 1024; i++) rom_b[i] = ib(OP_HALT, 10'd0, 10'd0, 10'd0);
    endtask

    task automatic run_a(output int n);
        start_a = 1'b1; tick(); start_a = 1'b0;
        n = 0;
        while (!(done_a || fault_a) && n < 400) begin tick(); n++; end
    endtask

    task automatic run_b(output int n);
        start_b = 1'b1; tick(); start_b = 1'b0;
        n = 0;
        while (!(done_b || fault_b) && n < 400) begin tick(); n++; end
    endtask

    task automatic pulse_ack_a();
        ack_a = 1'b1; tick(); ack_a = 1'b0;
    endtask

    task automatic pulse_ack_b();
        ack_b = 1'b1; tick(); ack_b = 1'b0;
    endtask

    task automatic load_add_prog();
        clear_rom_a();
        rom_a[0] = ia(OP_LDC, 8'd0, 8'h7F, 8'd0);
        rom_a[1] = ia(OP_LDC, 8'd1, 8'h01, 8'd0);
        rom_a[2] = ia(OP_ADD, 8'd2, 8'd0, 8'd1);
    endtask

    initial begin
        total = 0; bad = 0; viol_a = 0; xfer_a = 0; xfer_b = 0;
        wcnt_a = 0; wcnt_b = 0; waits_a = 0; waits_b = 0;
        start_a = 0; ack_a = 0; start_b = 0; ack_b = 0;
        clear_rom_a(); clear_rom_b();
        reset = 1'b1;
        tick(); tick();
        chk("rst_pc",    pc_a, 0);
        chk("rst_busy",  busy_a, 0);
        chk("rst_done",  done_a, 0);
        chk("rst_fault", fault_a, 0);
        chk("rst_fc",    fc_a, 0);
        chk("rst_carry", carry_a, 0);
        chk("rst_req",   ifa.mem_req, 0);
        chk("rst_addr",  ifa.mem_addr, 0);
        chk("rst_wdata", ifa.mem_wdata, 0);
        chk("rst_pc_b",  pc_b, 0);
        reset = 1'b0;
        tick();

        // 0x7F + 0x01, zero-wait
        load_add_prog();
        x0 = xfer_a;
        run_a(cyc);
        chk("add_cycles", cyc, 13);
        chk("add_m2",     dm_a[2], 8'h80);
        chk("add_carry",  carry_a, 0);
        chk("add_done",   done_a, 1);
        chk("add_pc",     pc_a, 3);
        chk("add_xfers",  xfer_a - x0, 5);
        tick();
        chk("done_held",  done_a, 1);
        pulse_ack_a();
        chk("ack_done",   done_a, 0);
        chk("ack_busy",   busy_a, 0);

        // 0xFF + 1 wraps and sets carry, then JC is taken
        clear_rom_a();
        rom_a[0] = ia(OP_LDC, 8'd0, 8'hFF, 8'd0);
        rom_a[1] = ia(OP_LDC, 8'd1, 8'h01, 8'd0);
        rom_a[2] = ia(OP_ADD, 8'd2, 8'd0, 8'd1);
        rom_a[3] = ia(OP_JC,  8'd7, 8'd0, 8'd0);
        run_a(cyc);
        chk("jc_cycles", cyc, 15);
        chk("jc_m2",     dm_a[2], 8'h00);
        chk("jc_carry",  carry_a, 1);
        chk("jc_pc",     pc_a, 7);
        pulse_ack_a();

        // same add program with 3 wait cycles per access
        load_add_prog();
        waits_a = 3;
        x0 = xfer_a;
        run_a(cyc);
        waits_a = 0;
        chk("wait_cycles", cyc, 28);
        chk("wait_m2",     dm_a[2], 8'h80);
        chk("wait_carry",  carry_a, 0);
        chk("wait_xfers",  xfer_a - x0, 5);
        chk("wait_stable", viol_a, 0);
        pulse_ack_a();

        // JC not taken (carry cleared at start), JMP, CALL/RET
        clear_rom_a();
        rom_a[0]  = ia(OP_JC,   8'd5,  8'd0, 8'd0);
        rom_a[1]  = ia(OP_JMP,  8'd3,  8'd0, 8'd0);
        rom_a[3]  = ia(OP_CALL, 8'd10, 8'd0, 8'd0);
        rom_a[10] = ia(OP_RET,  8'd0,  8'd0, 8'd0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("start_carry", carry_a, 0);
        repeat (6) tick();
        chk("call_pc", pc_a, 10);
        repeat (2) tick();
        chk("ret_pc", pc_a, 4);
        repeat (2) tick();
        chk("call_done", done_a, 1);
        chk("call_end_pc", pc_a, 4);
        pulse_ack_a();

        // conditional jumps and one-operand/logic ops
        clear_rom_a();
        rom_a[0]  = ia(OP_LDC,  8'd0,  8'h80, 8'd0);
        rom_a[1]  = ia(OP_JLT0, 8'd4,  8'd0,  8'd0);
        rom_a[4]  = ia(OP_JGT0, 8'd8,  8'd0,  8'd0);
        rom_a[5]  = ia(OP_JEQ0, 8'd9,  8'd0,  8'd0);
        rom_a[6]  = ia(OP_LDC,  8'd1,  8'd0,  8'd0);
        rom_a[7]  = ia(OP_JEQ0, 8'd12, 8'd1,  8'd0);
        rom_a[12] = ia(OP_COPY, 8'd3,  8'd0,  8'd0);
        rom_a[13] = ia(OP_INV,  8'd4,  8'd0,  8'd0);
        rom_a[14] = ia(OP_LDC,  8'd2,  8'd3,  8'd0);
        rom_a[15] = ia(OP_RSH,  8'd5,  8'd0,  8'd2);
        rom_a[16] = ia(OP_SUB,  8'd6,  8'd1,  8'd2);
        rom_a[17] = ia(OP_XOR,  8'd7,  8'd0,  8'd4);
        rom_a[18] = ia(OP_AND,  8'd8,  8'd0,  8'd7);
        rom_a[19] = ia(OP_OR,   8'd9,  8'd1,  8'd2);
        run_a(cyc);
        chk("br_pc",   pc_a, 20);
        chk("copy_m3", dm_a[3], 8'h80);
        chk("inv_m4",  dm_a[4], 8'h7F);
        chk("rsh_m5",  dm_a[5], 8'h10);
        chk("sub_m6",  dm_a[6], 8'hFD);
        chk("xor_m7",  dm_a[7], 8'hFF);
        chk("and_m8",  dm_a[8], 8'h80);
        chk("or_m9",   dm_a[9], 8'h03);
        chk("sub_carry", carry_a, 1);
        pulse_ack_a();

        // illegal opcode, ack keeps code, next start clears it
        clear_rom_a();
        rom_a[0] = ia(8'h20, 8'd0, 8'd0, 8'd0);
        run_a(cyc);
        chk("ill_fault", fault_a, 1);
        chk("ill_fc",    fc_a, 1);
        chk("ill_pc",    pc_a, 0);
        chk("ill_busy",  busy_a, 0);
        pulse_ack_a();
        chk("ill_ack_fault", fault_a, 0);
        chk("ill_ack_fc",    fc_a, 1);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("restart_fc", fc_a, 0);
        chk("restart_pc", pc_a, 0);
        tick();
        pulse_ack_a();

        // depth-2 stack overflow on the third nested CALL
        clear_rom_b();
        rom_b[0] = ib(OP_CALL, 10'd1, 10'd0, 10'd0);
        rom_b[1] = ib(OP_CALL, 10'd2, 10'd0, 10'd0);
        rom_b[2] = ib(OP_CALL, 10'd3, 10'd0, 10'd0);
        run_b(cyc);
        chk("ovf_fault", fault_b, 1);
        chk("ovf_fc",    fc_b, 2);
        chk("ovf_pc",    pc_b, 2);
        pulse_ack_b();

        // RET with empty stack
        clear_rom_b();
        rom_b[0] = ib(OP_RET, 10'd0, 10'd0, 10'd0);
        run_b(cyc);
        chk("unf_fc", fc_b, 3);
        chk("unf_pc", pc_b, 0);
        pulse_ack_b();

        // 16-bit data: borrow, shift saturation, LDC zero-extension
        clear_rom_b();
        rom_b[0] = ib(OP_LDC, 10'd0, 10'd0,   10'd0);
        rom_b[1] = ib(OP_LDC, 10'd1, 10'd1,   10'd0);
        rom_b[2] = ib(OP_SUB, 10'd2, 10'd0,   10'd1);
        rom_b[3] = ib(OP_LDC, 10'd3, 10'd16,  10'd0);
        rom_b[4] = ib(OP_LDC, 10'd4, 10'd5,   10'd0);
        rom_b[5] = ib(OP_LSH, 10'd5, 10'd4,   10'd3);
        rom_b[6] = ib(OP_LSH, 10'd6, 10'd4,   10'd1);
        rom_b[7] = ib(OP_LDC, 10'd7, 10'h3FF, 10'd0);
        run_b(cyc);
        chk("b_sub",   dm_b[2], 16'hFFFF);
        chk("b_carry", carry_b, 1);
        chk("b_lsh16", dm_b[5], 16'h0000);
        chk("b_lsh1",  dm_b[6], 16'h000A);
        chk("b_ldc",   dm_b[7], 16'h03FF);
        chk("b_pc",    pc_b, 8);
        pulse_ack_b();

        // asynchronous reset while a write is pending
        clear_rom_b();
        rom_b[0] = ib(OP_LDC, 10'd9, 10'd5, 10'd0);
        waits_b = 20;
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick(); tick();
        chk("wr_req", ifb.mem_req, 1);
        chk("wr_we",  ifb.mem_we, 1);
        reset = 1'b1;
        #1;
        chk("rst_wr_req",  ifb.mem_req, 0);
        chk("rst_wr_busy", busy_b, 0);
        tick();
        reset = 1'b0;
        waits_b = 0;
        tick();
        chk("rst_wr_idle", busy_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
